// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - FSM states, data-memory address windows and address screening
// Window bounds mirror DATA_CONST_ADDR_* / DATA_VAR_ADDR_* from config.v.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [31:0] DATA_CONST_ADDR_LO = 32'h0000_0000;
  localparam logic [31:0] DATA_CONST_ADDR_HI = 32'h0000_0FFF;
  localparam logic [31:0] DATA_VAR_ADDR_LO   = 32'h0000_1000;
  localparam logic [31:0] DATA_VAR_ADDR_HI   = 32'h0000_1FFF;

  // Offset-based range test keeps a zero lower bound from turning into a constant compare.
  function automatic logic addr_err(input logic [31:0] addr, input logic wr);
    logic in_const;
    logic in_var;
    in_const = (addr - DATA_CONST_ADDR_LO) <= (DATA_CONST_ADDR_HI - DATA_CONST_ADDR_LO);
    in_var   = (addr - DATA_VAR_ADDR_LO) <= (DATA_VAR_ADDR_HI - DATA_VAR_ADDR_LO);
    return !(in_const || in_var) || (wr && !in_var);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// rtl/data_mem_arbiter_rr_arbiter.sv - combinational round-robin picker
// The first requester at or after ptr (wrapping) wins; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_idx = IW'((int'(ptr) + i) % N);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the DataMemory port pair between NUM_REQ requesters
// One transaction in flight: IDLE grants, ISSUE drives memory, RESP pulses the owner.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [NUM_REQ-1:0]     Req_Valid,
  output logic [NUM_REQ-1:0]     Req_Ready,
  input  logic [NUM_REQ-1:0]     Req_Write,
  input  logic [32*NUM_REQ-1:0]  Req_Addr,
  input  logic [32*NUM_REQ-1:0]  Req_WData,
  output logic [NUM_REQ-1:0]     Resp_Valid,
  output logic [31:0]            Resp_Data,
  output logic                   Resp_Err,
  output logic                   Mem_ReadValid,
  output logic [31:0]            Mem_ReadAddr,
  input  logic [31:0]            Mem_ReadData,
  input  logic                   Mem_ReadReady,
  output logic                   Mem_WriteValid,
  output logic [31:0]            Mem_WriteAddr,
  output logic [31:0]            Mem_WriteData,
  output logic                   Busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e            r_state;
  state_e            w_next;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gnt;
  logic              r_write;
  logic              r_err;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [CW-1:0]     r_cnt;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gnt_idx;
  logic [31:0]        w_addr_arr  [NUM_REQ];
  logic [31:0]        w_wdata_arr [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_addr_arr[k]  = Req_Addr[32*k +: 32];
      w_wdata_arr[k] = Req_WData[32*k +: 32];
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (Req_Valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    Req_Ready      = '0;
    Resp_Valid     = '0;
    Resp_Data      = '0;
    Resp_Err       = 1'b0;
    Mem_ReadValid  = 1'b0;
    Mem_ReadAddr   = '0;
    Mem_WriteValid = 1'b0;
    Mem_WriteAddr  = '0;
    Mem_WriteData  = '0;
    Busy           = (r_state != ST_IDLE);
    unique case (r_state)
      ST_IDLE: begin
        Req_Ready = w_gnt;
        if (|Req_Valid) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        Mem_ReadAddr  = r_addr;
        Mem_WriteAddr = r_addr;
        Mem_WriteData = r_wdata;
        if (r_err) begin
          w_next = ST_RESP;
        end else if (r_write) begin
          Mem_WriteValid = 1'b1;
          w_next         = ST_RESP;
        end else begin
          Mem_ReadValid = 1'b1;
          if (Mem_ReadReady || (r_cnt == CNT_LAST)) w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        Resp_Valid[r_gnt] = 1'b1;
        Resp_Data         = r_rdata;
        Resp_Err          = r_err;
        w_next            = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_err doubles as the response error flag: address faults set it at grant, timeouts in ISSUE.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|Req_Valid) begin
            r_gnt   <= w_gnt_idx;
            r_write <= Req_Write[w_gnt_idx];
            r_addr  <= w_addr_arr[w_gnt_idx];
            r_wdata <= w_wdata_arr[w_gnt_idx];
            r_err   <= addr_err(w_addr_arr[w_gnt_idx], Req_Write[w_gnt_idx]);
            r_rdata <= '0;
          end
        end
        ST_ISSUE: begin
          if (!r_err && !r_write) begin
            if (Mem_ReadReady)          r_rdata <= Mem_ReadData;
            else if (r_cnt == CNT_LAST) r_err   <= 1'b1;
            else                        r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_ptr <= (r_gnt == IW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter with a DataMemory model
module tb_data_mem_arbiter;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [1:0]  Req_Valid, Req_Ready, Req_Write, Resp_Valid;
  logic [63:0] Req_Addr, Req_WData;
  logic [31:0] Resp_Data, Mem_ReadAddr, Mem_ReadData, Mem_WriteAddr, Mem_WriteData;
  logic        Resp_Err, Mem_ReadValid, Mem_ReadReady, Mem_WriteValid, Busy;

  logic [31:0] addr_a [2];
  logic [31:0] wdata_a [2];
  logic [31:0] mem [0:2047];
  bit          ready_en = 1'b1;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   w0;

  assign Req_Addr      = {addr_a[1], addr_a[0]};
  assign Req_WData     = {wdata_a[1], wdata_a[0]};
  assign Mem_ReadData  = mem[Mem_ReadAddr[12:2]];
  assign Mem_ReadReady = ready_en & Mem_ReadValid;

  data_mem_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
    .Req_Addr(Req_Addr), .Req_WData(Req_WData),
    .Resp_Valid(Resp_Valid), .Resp_Data(Resp_Data), .Resp_Err(Resp_Err),
    .Mem_ReadValid(Mem_ReadValid), .Mem_ReadAddr(Mem_ReadAddr),
    .Mem_ReadData(Mem_ReadData), .Mem_ReadReady(Mem_ReadReady),
    .Mem_WriteValid(Mem_WriteValid), .Mem_WriteAddr(Mem_WriteAddr),
    .Mem_WriteData(Mem_WriteData), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (Mem_WriteValid) begin
      mem[Mem_WriteAddr[12:2]] = Mem_WriteData;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RSTn && Resp_Valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {30'd0, Resp_Valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_port", {30'd0, Resp_Valid}, 32'd1 << e.port);
        chk("resp_data", Resp_Data, e.data);
        chk("resp_err", {31'd0, Resp_Err}, {31'd0, e.err});
        chk("resp_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input int port, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input int lat, input bit push);
    bit got;
    got = 1'b0;
    addr_a[port]    = addr;
    wdata_a[port]   = wdata;
    Req_Write[port] = wr;
    Req_Valid[port] = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge CLK);
      if (Req_Ready[port]) begin
        got = 1'b1;
        if (push) sb.push_back('{port, exp_data, exp_err, cyc + lat});
      end
    end
    chk($sformatf("handshake_p%0d_%08h", port, addr), 32'(got), 32'd1);
    @(posedge CLK);
    #1;
    Req_Valid[port] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      @(negedge CLK);
      #1;
    end
    chk("resp_outstanding", 32'(sb.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    Req_Valid = '0;
    Req_Write = '0;
    for (int i = 0; i < 2; i++) begin
      addr_a[i]  = '0;
      wdata_a[i] = '0;
    end
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[0] = 32'h0000_0810;
    mem[4] = 32'h1234_5678;

    repeat (2) @(negedge CLK);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_req_ready", {30'd0, Req_Ready}, 32'd0);
    chk("reset_resp_valid", {30'd0, Resp_Valid}, 32'd0);
    chk("reset_strobes", {30'd0, Mem_ReadValid, Mem_WriteValid}, 32'd0);
    chk("reset_waddr", Mem_WriteAddr, 32'd0);
    @(posedge CLK);
    #1 RSTn = 1'b1;

    issue(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0810, 1'b0, 2, 1'b1);
    drain();

    w0 = wr_cnt;
    issue(1, 1'b1, 32'h0000_1000, 32'h0000_00AB, 32'h0, 1'b0, 2, 1'b1);
    drain();
    chk("write_pulse_count", 32'(wr_cnt - w0), 32'd1);
    chk("write_mem_word", mem[32'h1000 >> 2], 32'h0000_00AB);

    addr_a[0] = 32'h0000_1000;
    addr_a[1] = 32'h0000_0000;
    Req_Write = 2'b00;
    Req_Valid = 2'b11;
    for (int t = 0; t < 6; t++) begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge CLK);
        if (Req_Ready != 2'b00) got = 1'b1;
      end
      chk($sformatf("rr_grant%0d", t), {30'd0, Req_Ready}, (t % 2 == 0) ? 32'd1 : 32'd2);
      if (got) begin
        if (Req_Ready[1]) sb.push_back('{1, 32'h0000_0810, 1'b0, cyc + 2});
        else              sb.push_back('{0, 32'h0000_00AB, 1'b0, cyc + 2});
      end
      @(posedge CLK);
      #1;
      if (t == 5) Req_Valid = 2'b00;
    end
    drain();

    w0 = wr_cnt;
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b1, 2, 1'b1);
    drain();
    chk("const_write_no_strobe", 32'(wr_cnt - w0), 32'd0);
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 2, 1'b1);
    drain();

    issue(1, 1'b0, 32'h0000_2000, 32'h0, 32'h0, 1'b1, 2, 1'b1);
    drain();
    issue(0, 1'b1, 32'h0000_1FFC, 32'h5A5A_0001, 32'h0, 1'b0, 2, 1'b1);
    drain();
    issue(1, 1'b0, 32'h0000_1FFC, 32'h0, 32'h5A5A_0001, 1'b0, 2, 1'b1);
    drain();

    ready_en = 1'b0;
    issue(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b1, TO + 1, 1'b1);
    drain();
    ready_en = 1'b1;

    issue(1, 1'b1, 32'h0000_1004, 32'h0000_0055, 32'h0, 1'b0, 2, 1'b0);
    chk("issue_write_strobe", {31'd0, Mem_WriteValid}, 32'd1);
    chk("issue_busy", {31'd0, Busy}, 32'd1);
    #2 RSTn = 1'b0;
    #1;
    chk("rst_strobe_cut", {31'd0, Mem_WriteValid}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_waddr", Mem_WriteAddr, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RSTn = 1'b1;
    chk("rst_mem_unwritten", mem[32'h1004 >> 2], 32'd0);
    issue(0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_00AB, 1'b0, 2, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
